// File: rtl/dram_cmd_scheduler.sv
// dram_cmd_scheduler: open-page DRAM command sequencer.
// Accepts one decoded request at a time, tracks the open row of every bank,
// and expands each request into RW / ACT,RW / PRE,ACT,RW commands, each issued
// over a 4-phase cmd_req/cmd_ack handshake.
// Optional periodic refresh sweep (PRE to all open banks) is enabled by
// defining the macro DRAM_SCHED_REFRESH_EN.
module dram_cmd_scheduler #(
    parameter int unsigned NUM_OF_BANKS     = 8,
    parameter int unsigned NUM_OF_ROWS      = 128,
    parameter int unsigned NUM_OF_COLS      = 8,
    parameter int unsigned REFRESH_INTERVAL = 1024,
    localparam int unsigned BANK_W          = $clog2(NUM_OF_BANKS),
    localparam int unsigned ROW_W           = $clog2(NUM_OF_ROWS),
    localparam int unsigned COL_W           = $clog2(NUM_OF_COLS)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_rw,
    input  logic [BANK_W-1:0] req_bank,
    input  logic [ROW_W-1:0]  req_row,
    input  logic [COL_W-1:0]  req_col,
    output logic              req_done,
    output logic              cmd_req,
    input  logic              cmd_ack,
    output logic [1:0]        cmd,
    output logic [BANK_W-1:0] cmd_bank,
    output logic [ROW_W-1:0]  cmd_row,
    output logic [COL_W-1:0]  cmd_col,
    output logic [15:0]       row_hit_cnt
);

    localparam logic [1:0] CMD_ACT = 2'b00;
    localparam logic [1:0] CMD_RD  = 2'b01;
    localparam logic [1:0] CMD_WR  = 2'b10;
    localparam logic [1:0] CMD_PRE = 2'b11;

    // Elaboration sanity check on the refresh period
    if (REFRESH_INTERVAL < 2) begin : g_bad_interval
        $error("REFRESH_INTERVAL must be at least 2");
    end

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_RELEASE
    } state_t;

    state_t             state;
    logic               rw_q;
    logic [NUM_OF_BANKS-1:0] open_q;
    logic [ROW_W-1:0]   open_row [NUM_OF_BANKS];
    logic               cur_open;
    logic               cur_hit;

`ifdef DRAM_SCHED_REFRESH_EN
    localparam int unsigned REF_W = $clog2(REFRESH_INTERVAL);

    logic [REF_W-1:0]   ref_cnt;
    logic               refresh_pending;
    logic               refreshing;
    logic               any_open;
    logic [BANK_W-1:0]  first_open;

    // Lowest-numbered open bank, for the ascending refresh sweep
    always_comb begin
        any_open   = 1'b0;
        first_open = '0;
        for (int i = 0; i < int'(NUM_OF_BANKS); i++) begin
            if (open_q[i] && !any_open) begin
                any_open   = 1'b1;
                first_open = BANK_W'(i);
            end
        end
    end
`endif

    // Classify the incoming request against the open-row table
    always_comb begin
        cur_open = open_q[req_bank];
        cur_hit  = cur_open && (open_row[req_bank] == req_row);
    end

    // Scheduler FSM, open-row table and registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= ST_IDLE;
            req_ready   <= 1'b0;
            req_done    <= 1'b0;
            cmd_req     <= 1'b0;
            cmd         <= CMD_ACT;
            cmd_bank    <= '0;
            cmd_row     <= '0;
            cmd_col     <= '0;
            row_hit_cnt <= '0;
            rw_q        <= 1'b0;
            open_q      <= '0;
`ifdef DRAM_SCHED_REFRESH_EN
            ref_cnt         <= '0;
            refresh_pending <= 1'b0;
            refreshing      <= 1'b0;
`endif
        end else begin
            req_done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (req_valid && req_ready) begin
                        // Accept: latch fields and load the first command
                        rw_q     <= req_rw;
                        cmd_bank <= req_bank;
                        cmd_row  <= req_row;
                        cmd_col  <= req_col;
                        if (cur_hit) begin
                            cmd <= req_rw ? CMD_WR : CMD_RD;
                            if (row_hit_cnt != 16'hFFFF) begin
                                row_hit_cnt <= row_hit_cnt + 16'd1;
                            end
                        end else if (!cur_open) begin
                            cmd <= CMD_ACT;
                        end else begin
                            cmd <= CMD_PRE;
                        end
                        cmd_req   <= 1'b1;
                        req_ready <= 1'b0;
                        state     <= ST_ISSUE;
                    end
`ifdef DRAM_SCHED_REFRESH_EN
                    else if (refresh_pending) begin
                        if (any_open) begin
                            cmd        <= CMD_PRE;
                            cmd_bank   <= first_open;
                            cmd_req    <= 1'b1;
                            req_ready  <= 1'b0;
                            refreshing <= 1'b1;
                            state      <= ST_ISSUE;
                        end else begin
                            refresh_pending <= 1'b0;
                            req_ready       <= 1'b1;
                        end
                    end
`endif
                    else begin
                        req_ready <= 1'b1;
                    end
                end

                ST_ISSUE: begin
                    // Table update lands with the acknowledge of the command
                    if (cmd_ack) begin
                        cmd_req <= 1'b0;
                        state   <= ST_RELEASE;
                        if (cmd == CMD_ACT) begin
                            open_q[cmd_bank]   <= 1'b1;
                            open_row[cmd_bank] <= cmd_row;
                        end else if (cmd == CMD_PRE) begin
                            open_q[cmd_bank] <= 1'b0;
                        end
                    end
                end

                ST_RELEASE: begin
                    if (!cmd_ack) begin
`ifdef DRAM_SCHED_REFRESH_EN
                        if (refreshing) begin
                            if (any_open) begin
                                cmd_bank <= first_open;
                                cmd_req  <= 1'b1;
                                state    <= ST_ISSUE;
                            end else begin
                                refreshing      <= 1'b0;
                                refresh_pending <= 1'b0;
                                req_ready       <= 1'b1;
                                state           <= ST_IDLE;
                            end
                        end else
`endif
                        begin
                            case (cmd)
                                CMD_PRE: begin
                                    cmd     <= CMD_ACT;
                                    cmd_req <= 1'b1;
                                    state   <= ST_ISSUE;
                                end
                                CMD_ACT: begin
                                    cmd     <= rw_q ? CMD_WR : CMD_RD;
                                    cmd_req <= 1'b1;
                                    state   <= ST_ISSUE;
                                end
                                default: begin
                                    req_done <= 1'b1;
`ifdef DRAM_SCHED_REFRESH_EN
                                    req_ready <= !refresh_pending;
`else
                                    req_ready <= 1'b1;
`endif
                                    state <= ST_IDLE;
                                end
                            endcase
                        end
                    end
                end

                default: begin
                    state <= ST_IDLE;
                end
            endcase

`ifdef DRAM_SCHED_REFRESH_EN
            // Free-running refresh timer; a new expiry wins over a same-cycle clear
            if (ref_cnt == REF_W'(REFRESH_INTERVAL - 1)) begin
                ref_cnt         <= '0;
                refresh_pending <= 1'b1;
            end else begin
                ref_cnt <= ref_cnt + REF_W'(1);
            end
`endif
        end
    end

endmodule

// File: tb/tb_dram_cmd_scheduler.sv
// Directed testbench for dram_cmd_scheduler: table of requests with
// hand-computed command sequences, latencies and hit counts, plus hand-written
// stalled-ack, mid-handshake reset and refresh sequences.
module tb_dram_cmd_scheduler;

    localparam logic [1:0] C_ACT = 2'b00;
    localparam logic [1:0] C_RD  = 2'b01;
    localparam logic [1:0] C_WR  = 2'b10;
    localparam logic [1:0] C_PRE = 2'b11;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic        req_rw;
    logic [2:0]  req_bank;
    logic [6:0]  req_row;
    logic [2:0]  req_col;
    logic        req_done;
    logic        cmd_req;
    logic        cmd_ack;
    logic [1:0]  cmd;
    logic [2:0]  cmd_bank;
    logic [6:0]  cmd_row;
    logic [2:0]  cmd_col;
    logic [15:0] row_hit_cnt;

    logic        ack_en;

    dram_cmd_scheduler #(
        .NUM_OF_BANKS(8),
        .NUM_OF_ROWS(128),
        .NUM_OF_COLS(8),
        .REFRESH_INTERVAL(64)
    ) dut (
        .clk(clk),
        .rst(rst),
        .req_valid(req_valid),
        .req_ready(req_ready),
        .req_rw(req_rw),
        .req_bank(req_bank),
        .req_row(req_row),
        .req_col(req_col),
        .req_done(req_done),
        .cmd_req(cmd_req),
        .cmd_ack(cmd_ack),
        .cmd(cmd),
        .cmd_bank(cmd_bank),
        .cmd_row(cmd_row),
        .cmd_col(cmd_col),
        .row_hit_cnt(row_hit_cnt)
    );

    always #5 clk = ~clk;

    // DRAM-side responder: ack follows req one cycle later unless stalled
    always @(posedge clk) begin
        if (rst) cmd_ack <= 1'b0;
        else if (ack_en) cmd_ack <= cmd_req;
    end

    typedef struct packed {
        logic [1:0] c;
        logic [2:0] b;
        logic [6:0] r;
        logic [2:0] col;
    } ent_t;

    ent_t log_q [$];
    int   bad_rise = 0;
    int   unstable = 0;

    // Command monitor: log every cmd_req rise, flag field changes and rises under ack
    initial begin
        ent_t cur;
        ent_t prev_ent;
        logic prev_req;
        prev_req = 1'b0;
        prev_ent = '0;
        forever begin
            @(negedge clk);
            cur = {cmd, cmd_bank, cmd_row, cmd_col};
            if (cmd_req === 1'b1 && prev_req !== 1'b1) begin
                log_q.push_back(cur);
                if (cmd_ack === 1'b1) bad_rise++;
            end else if (cmd_req === 1'b1 && cur !== prev_ent) begin
                unstable++;
            end
            prev_req = cmd_req;
            prev_ent = cur;
        end
    end

    typedef struct {
        logic       rw;
        logic [2:0] bank;
        logic [6:0] row;
        logic [2:0] col;
        int         ncmd;
        logic [1:0] c0;
        logic [1:0] c1;
        logic [1:0] c2;
        int         lat;
        int         hits;
    } vec_t;

    vec_t vt [13];
    int   checks = 0;
    int   errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic wait_ready();
        int n;
        n = 0;
        @(negedge clk);
        while (req_ready !== 1'b1 && n < 300) begin
            @(negedge clk);
            n++;
        end
        chk("ready_wait", 32'(req_ready), 32'd1);
    endtask

    // Apply one table entry and compare commands, latency, hit count
    task automatic do_vec(input int idx);
        vec_t       v;
        int         base;
        int         lat;
        int         got;
        bit         seen;
        ent_t       e;
        logic [1:0] ec;
        v = vt[idx];
        wait_ready();
        req_valid = 1'b1;
        req_rw    = v.rw;
        req_bank  = v.bank;
        req_row   = v.row;
        req_col   = v.col;
        base      = log_q.size();
        @(posedge clk);
        #1 req_valid = 1'b0;
        lat  = 0;
        seen = 1'b0;
        while (!seen && lat < 100) begin
            @(posedge clk);
            #1;
            lat++;
            if (req_done === 1'b1) seen = 1'b1;
        end
        chk($sformatf("v%0d_latency", idx), 32'(lat), 32'(v.lat));
        chk($sformatf("v%0d_ready_at_done", idx), 32'(req_ready), 32'd1);
        chk($sformatf("v%0d_hits", idx), 32'(row_hit_cnt), 32'(v.hits));
        @(posedge clk);
        #1;
        chk($sformatf("v%0d_done_pulse", idx), 32'(req_done), 32'd0);
        got = log_q.size() - base;
        chk($sformatf("v%0d_ncmd", idx), 32'(got), 32'(v.ncmd));
        for (int k = 0; k < v.ncmd && k < got; k++) begin
            e  = log_q[base + k];
            ec = (k == 0) ? v.c0 : ((k == 1) ? v.c1 : v.c2);
            chk($sformatf("v%0d_cmd%0d_code", idx, k), 32'(e.c), 32'(ec));
            chk($sformatf("v%0d_cmd%0d_bank", idx, k), 32'(e.b), 32'(v.bank));
            if (ec == C_ACT) chk($sformatf("v%0d_cmd%0d_row", idx, k), 32'(e.r), 32'(v.row));
            if (ec == C_RD || ec == C_WR) chk($sformatf("v%0d_cmd%0d_col", idx, k), 32'(e.col), 32'(v.col));
        end
    endtask

    initial begin
        logic [1:0] h_cmd;
        logic [2:0] h_bank;
        logic [2:0] h_col;
        bit         ok;
        int         n;
        int         base;
        ent_t       e;

        vt[0]  = '{1'b1, 3'd3, 7'd5,   3'd2, 2, C_ACT, C_WR,  C_WR, 8,  0};
        vt[1]  = '{1'b0, 3'd3, 7'd5,   3'd7, 1, C_RD,  C_RD,  C_RD, 4,  1};
        vt[2]  = '{1'b1, 3'd3, 7'd9,   3'd0, 3, C_PRE, C_ACT, C_WR, 12, 1};
        vt[3]  = '{1'b0, 3'd3, 7'd9,   3'd1, 1, C_RD,  C_RD,  C_RD, 4,  2};
        vt[4]  = '{1'b0, 3'd0, 7'd127, 3'd7, 2, C_ACT, C_RD,  C_RD, 8,  2};
        vt[5]  = '{1'b1, 3'd7, 7'd0,   3'd0, 2, C_ACT, C_WR,  C_WR, 8,  2};
        vt[6]  = '{1'b1, 3'd7, 7'd0,   3'd3, 1, C_WR,  C_WR,  C_WR, 4,  3};
        vt[7]  = '{1'b0, 3'd0, 7'd126, 3'd0, 3, C_PRE, C_ACT, C_RD, 12, 3};
        vt[8]  = '{1'b0, 3'd3, 7'd9,   3'd4, 2, C_ACT, C_RD,  C_RD, 8,  0};
        vt[9]  = '{1'b1, 3'd4, 7'd1,   3'd6, 2, C_ACT, C_WR,  C_WR, 8,  0};
        vt[10] = '{1'b0, 3'd1, 7'd2,   3'd0, 2, C_ACT, C_RD,  C_RD, 8,  0};
        vt[11] = '{1'b1, 3'd6, 7'd3,   3'd1, 2, C_ACT, C_WR,  C_WR, 8,  0};
        vt[12] = '{1'b0, 3'd1, 7'd2,   3'd3, 2, C_ACT, C_RD,  C_RD, 8,  0};

        rst       = 1'b1;
        ack_en    = 1'b1;
        req_valid = 1'b0;
        req_rw    = 1'b0;
        req_bank  = '0;
        req_row   = '0;
        req_col   = '0;
        repeat (3) @(negedge clk);

        // Reset state
        chk("rst_req_ready", 32'(req_ready), 32'd0);
        chk("rst_cmd_req", 32'(cmd_req), 32'd0);
        chk("rst_cmd_fields", 32'({cmd, cmd_bank, cmd_row, cmd_col}), 32'd0);
        chk("rst_req_done", 32'(req_done), 32'd0);
        chk("rst_hits", 32'(row_hit_cnt), 32'd0);
        rst = 1'b0;
        @(negedge clk);
        chk("post_rst_ready", 32'(req_ready), 32'd1);

`ifdef DRAM_SCHED_REFRESH_EN
        // Open banks 1 and 6 before the first refresh expiry
        do_vec(10);
        do_vec(11);
        base = log_q.size();
        ok   = 1'b1;
        n    = 0;
        while ((log_q.size() < base + 2 || cmd_req === 1'b1) && n < 300) begin
            @(negedge clk);
            n++;
            if (cmd_req === 1'b1 && req_ready !== 1'b0) ok = 1'b0;
            if (req_done === 1'b1) ok = 1'b0;
        end
        chk("refresh_ready_low", 32'(ok), 32'd1);
        chk("refresh_ncmd", 32'(log_q.size() - base), 32'd2);
        if (log_q.size() >= base + 2) begin
            e = log_q[base];
            chk("refresh0_code", 32'(e.c), 32'(C_PRE));
            chk("refresh0_bank", 32'(e.b), 32'd1);
            e = log_q[base + 1];
            chk("refresh1_code", 32'(e.c), 32'(C_PRE));
            chk("refresh1_bank", 32'(e.b), 32'd6);
        end
        do_vec(12);
`else
        for (int i = 0; i < 8; i++) do_vec(i);

        // Stalled acknowledge: request held stable, no completion
        ack_en = 1'b0;
        wait_ready();
        req_valid = 1'b1;
        req_rw    = 1'b0;
        req_bank  = 3'd7;
        req_row   = 7'd0;
        req_col   = 3'd5;
        @(posedge clk);
        #1 req_valid = 1'b0;
        @(negedge clk);
        chk("stall_cmd_req", 32'(cmd_req), 32'd1);
        h_cmd  = cmd;
        h_bank = cmd_bank;
        h_col  = cmd_col;
        ok     = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (cmd_req !== 1'b1 || cmd !== h_cmd || cmd_bank !== h_bank || cmd_col !== h_col) ok = 1'b0;
            if (req_ready !== 1'b0 || req_done !== 1'b0) ok = 1'b0;
        end
        chk("stall_hold_stable", 32'(ok), 32'd1);
        chk("stall_cmd", 32'(h_cmd), 32'(C_RD));
        chk("stall_bank", 32'(h_bank), 32'd7);
        chk("stall_col", 32'(h_col), 32'd5);
        chk("stall_hits", 32'(row_hit_cnt), 32'd4);
        ack_en = 1'b1;
        n  = 0;
        ok = 1'b0;
        while (!ok && n < 50) begin
            @(negedge clk);
            n++;
            if (req_done === 1'b1) ok = 1'b1;
        end
        chk("stall_done_after_ack", 32'(ok), 32'd1);

        // Reset while an ACT is being issued
        ack_en = 1'b0;
        wait_ready();
        req_valid = 1'b1;
        req_rw    = 1'b1;
        req_bank  = 3'd4;
        req_row   = 7'd1;
        req_col   = 3'd0;
        @(posedge clk);
        #1 req_valid = 1'b0;
        @(negedge clk);
        chk("midrst_issue_req", 32'(cmd_req), 32'd1);
        chk("midrst_issue_cmd", 32'(cmd), 32'(C_ACT));
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk("midrst_cmd_req", 32'(cmd_req), 32'd0);
        chk("midrst_ready", 32'(req_ready), 32'd0);
        chk("midrst_hits", 32'(row_hit_cnt), 32'd0);
        @(negedge clk);
        rst    = 1'b0;
        ack_en = 1'b1;
        do_vec(8);
        do_vec(9);
`endif

        repeat (4) @(negedge clk);
        chk("no_rise_under_ack", 32'(bad_rise), 32'd0);
        chk("fields_stable_in_issue", 32'(unstable), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/dram_cmd_scheduler.md
Name: dram_cmd_scheduler

Overview:
- Sits between the L2 request buffer/address translator and the DRAM command interface (cmd_req/cmd_ack handshake toward the bank model).
- Accepts one decoded request at a time (bank/row/col plus read/write) and keeps an open-row table per bank (open-page policy).
- Expands each request into the minimal command sequence: hit = RW; closed bank = ACT, RW; conflict = PRE, ACT, RW.
- Issues each command over a 4-phase req/ack handshake.

Parameters:
- NUM_OF_BANKS, 8, number of banks; BANK_W = $clog2(NUM_OF_BANKS).
- NUM_OF_ROWS, 128, rows per bank; ROW_W = $clog2(NUM_OF_ROWS).
- NUM_OF_COLS, 8, columns per row; COL_W = $clog2(NUM_OF_COLS).
- REFRESH_INTERVAL, 1024, cycles between refresh sweeps; used only with the optional feature.

Ports:
- clk  in  1  clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset. The name drops the _b suffix because the polarity is high.
- req_valid  in  1  request present.
- req_ready  out  1  scheduler can accept a request.
- req_rw  in  1  1 = write, 0 = read.
- req_bank  in  BANK_W  target bank.
- req_row  in  ROW_W  target row.
- req_col  in  COL_W  target column.
- req_done  out  1  one-cycle pulse when the final RD/WR command of a request completes its handshake.
- cmd_req  out  1  command request (4-phase).
- cmd_ack  in  1  command acknowledge from DRAM side.
- cmd  out  2  command code: 00 ACT, 01 RD, 10 WR, 11 PRE.
- cmd_bank  out  BANK_W  command bank.
- cmd_row  out  ROW_W  command row; valid for ACT.
- cmd_col  out  COL_W  command column; valid for RD/WR.
- row_hit_cnt  out  16  saturating count of requests that were row hits.

Behaviour:
- Reset (rst=1 at an edge):
  - All outputs go to 0: req_ready=0 during reset, cmd_req=0, cmd=00, cmd_bank/row/col=0, req_done=0, row_hit_cnt=0.
  - Open-row table: all banks closed. FSM goes to IDLE.
  - Reset mid-handshake drops cmd_req at that edge and discards the in-flight request.
- States:
  - IDLE: req_ready=1 (0 if a refresh is pending).
  - On req_valid && req_ready, latch rw/bank/row/col, classify hit/closed/conflict, load the command list, and go to ISSUE next cycle.
  - ISSUE: cmd_req=1; cmd/cmd_bank/cmd_row/cmd_col stay stable for the whole state. Stay until cmd_ack is sampled 1, then go to RELEASE.
  - RELEASE: cmd_req=0. Stay until cmd_ack is sampled 0.
    - If commands remain, go to ISSUE with the next command.
    - Otherwise pulse req_done for one cycle and go to IDLE (req_ready=1 in that same cycle).
- Table updates take effect at the cmd_ack=1 sample of the issuing command:
  - ACT sets open[bank]=1 and open_row[bank]=row.
  - PRE clears open[bank].
- Latency: with cmd_ack returning 1 cycle after a level change, a hit request takes accept + 4 cycles to req_done. Each additional command adds 4 cycles.
- Classification:
  - hit = open[bank] && open_row[bank]==row. A hit increments row_hit_cnt at accept; the count saturates at 16'hFFFF.
  - closed = !open[bank].
  - conflict = open to a different row.
- Handshake rules:
  - Only one command is in flight.
  - cmd_req never rises while cmd_ack=1.
  - cmd_ack staying 1 indefinitely holds the FSM in RELEASE. This is not an error.
- Out-of-range values are impossible by width (power-of-two parameters). Non-power-of-two configurations are unsupported.
- req_valid while req_ready=0 is ignored; requester fields need not be held by this block.

Optional Feature:
- Macro: DRAM_SCHED_REFRESH_EN.
- Enabled:
  - A free-running counter, cleared by reset, sets refresh_pending every REFRESH_INTERVAL cycles.
  - While refresh_pending, req_ready=0 once the current request finishes.
  - The scheduler then issues PRE to every open bank in ascending bank order, one handshake each, clears the table, and clears refresh_pending.
  - A refresh that expires mid-request waits for req_done.
  - If no bank is open, refresh_pending clears in one cycle.
- Disabled: no counter; rows stay open until a conflict; REFRESH_INTERVAL is unused.

Test Plan:
- Reset, then write bank 3/row 5/col 2 with ack delay 1: cmd sequence ACT(3,5), then WR(3,col 2); req_done at accept+8; row_hit_cnt=0.
- Read bank 3/row 5/col 7 following the previous request: single RD(3,col 7); req_done at accept+4; row_hit_cnt=1.
- Write bank 3/row 9: PRE(3), ACT(3,9), WR; open_row[3]=9 afterward.
- Hold cmd_ack=0 for 20 cycles after cmd_req rises: cmd_req stays 1 and cmd fields stay stable; req_ready=0 throughout; no req_done.
- Assert rst during ISSUE of an ACT: cmd_req=0 next cycle; a following request to the same bank/row issues ACT again (table cleared).
- With DRAM_SCHED_REFRESH_EN, REFRESH_INTERVAL=64, and banks 1 and 6 open: at expiry, PRE(1) then PRE(6); req_ready=0 until done; the next request to bank 1 issues ACT.
